// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: 3-stage hit/address/colour pipeline plus ping-pong animation.
// Optional horizontal mirroring via `define SPRITE_FLIP_EN (adds flip_h input).
module sprite_pixel_fetch #(
  parameter logic [23:0] KEY_COLOR = 24'h000000,
  parameter int          FRAME_DIV = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        ghost_mode,
  input  logic        anim_en,
`ifdef SPRITE_FLIP_EN
  input  logic        flip_h,
`endif
  input  logic [23:0] rom_data,
  output logic [18:0] read_address,
  output logic [2:0]  frame_sel,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb
);

  localparam logic [5:0] DIV_M1 = 6'(FRAME_DIV - 1);

  typedef enum logic {UP, DOWN} dir_t;

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        hit_x;
  logic        hit_y;
  logic        hit;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [2:0]  col_f;
  logic        hit_d1;
  logic        hit_d2;

  logic [1:0]  fc_sync;
  logic        fc_prev;
  logic        pulse;
  logic [5:0]  presc;
  logic        step;

  dir_t        state;
  dir_t        state_nxt;
  logic [2:0]  anim_idx;
  logic [2:0]  idx_nxt;
  logic [2:0]  sel_nxt;

  // 11-bit compare so a sprite near the right edge never wraps to column 0
  assign x_end = {1'b0, sprite_x} + 11'd7;
  assign y_end = {1'b0, sprite_y} + 11'd7;
  assign hit_x = (DrawX >= sprite_x) && ({1'b0, DrawX} <= x_end);
  assign hit_y = (DrawY >= sprite_y) && ({1'b0, DrawY} <= y_end);
  assign hit   = hit_x && hit_y;
  assign row   = DrawY[2:0] - sprite_y[2:0];
  assign col   = DrawX[2:0] - sprite_x[2:0];

`ifdef SPRITE_FLIP_EN
  assign col_f = flip_h ? (3'd7 - col) : col;
`else
  assign col_f = col;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= 19'd64;
      frame_sel    <= 3'd0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      pixel_on     <= 1'b0;
      pixel_rgb    <= 24'h0;
    end else begin
      read_address <= hit ? {13'b0, row, col_f} : 19'd64;
      frame_sel    <= sel_nxt;
      hit_d1       <= hit;
      hit_d2       <= hit_d1;
      pixel_on     <= hit_d2 && (rom_data != KEY_COLOR);
      pixel_rgb    <= (hit_d2 && (rom_data != KEY_COLOR)) ? rom_data : 24'h0;
    end
  end

  assign pulse = fc_sync[1] && !fc_prev;
  assign step  = pulse && anim_en && (presc == DIV_M1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_sync <= 2'b00;
      fc_prev <= 1'b0;
      presc   <= 6'd0;
    end else begin
      fc_sync <= {fc_sync[0], frame_clk};
      fc_prev <= fc_sync[1];
      if (pulse && anim_en)
        presc <= (presc == DIV_M1) ? 6'd0 : presc + 6'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= UP;
      anim_idx <= 3'd0;
    end else begin
      state    <= state_nxt;
      anim_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = anim_idx;
    if (step) begin
      unique case (state)
        UP: begin
          idx_nxt = anim_idx + 3'd1;
          if (anim_idx == 3'd3) state_nxt = DOWN;
        end
        DOWN: begin
          idx_nxt = anim_idx - 3'd1;
          if (anim_idx == 3'd1) state_nxt = UP;
        end
      endcase
    end
  end

  always_comb begin
    sel_nxt = ghost_mode ? 3'd5 : anim_idx;
  end

endmodule

// File: doc/sprite_pixel_fetch.md
SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

Interface
REQ-001 The block SHALL be parameterised as follows:
- KEY_COLOR, default 24'h000000: transparent colour.
- FRAME_DIV, default 6: frame_clk rising edges per animation step; legal range 1..63.
REQ-002 The block SHALL have these ports:
- Clk  in  1  single clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  vertical-sync-rate strobe, asynchronous to Clk.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- sprite_x, sprite_y  in  10 each  sprite top-left corner.
- ghost_mode  in  1  select ghost image instead of animation.
- anim_en  in  1  animation advance enable.
- rom_data  in  24  selected sprite-memory word; 1-clock read latency.
- read_address  out  19  sprite-memory address.
- frame_sel  out  3  memory select: 0-4 animation frames, 5 ghost.
- pixel_on  out  1  opaque sprite pixel present.
- pixel_rgb  out  24  sprite colour, 0 when pixel_on=0.

Function
REQ-003 Hit SHALL be computed in 11-bit unsigned arithmetic: sprite_x<=DrawX<=sprite_x+7 and sprite_y<=DrawY<=sprite_y+7, with no wrap at 1023.
REQ-004 Stage 1 SHALL register the address: on hit, read_address = {13'b0, row[2:0], col[2:0]}, where row = DrawY-sprite_y and col = DrawX-sprite_x; on miss, read_address = 19'd64.
REQ-005 Stage 1 SHALL also register the hit flag, which is then delayed one more clock so it aligns with rom_data.
REQ-006 Stage 3 SHALL register the outputs: pixel_on = hit_d2 AND (rom_data != KEY_COLOR); pixel_rgb = rom_data when pixel_on is 1, else 24'h0.
REQ-007 Latency SHALL be exactly 3 clocks from DrawX/DrawY to pixel_on/pixel_rgb; the pipeline is always running, with no stalls.
REQ-008 frame_clk SHALL pass through a 2-flop synchronizer followed by a rising-edge detector that gives one pulse per edge.
REQ-009 A 6-bit prescaler SHALL count edge pulses while anim_en=1; at FRAME_DIV-1 it wraps to 0 and issues one step.
REQ-010 When anim_en=0, the prescaler and the animation state SHALL hold.
REQ-011 The animation FSM SHALL be a ping-pong sequence with states UP and DOWN and a 3-bit anim_idx:
- UP: increment; at 4 go to DOWN and decrement on the next step.
- DOWN: decrement; at 0 go to UP.
- Sequence: 0,1,2,3,4,3,2,1,0,1,...
REQ-012 frame_sel SHALL be 5 when ghost_mode=1, else anim_idx.
REQ-013 frame_sel SHALL be registered in stage 1 alongside read_address, so a mid-line change affects only pixels sampled after it.
REQ-014 The animation SHALL keep stepping while ghost_mode=1.
REQ-015 An edge pulse in the same clock as an anim_en 1->0 transition SHALL be ignored.

Reset
REQ-016 Asserting Reset SHALL immediately set the following, independent of Clk:
- read_address=19'd64, frame_sel=0, pixel_on=0, pixel_rgb=0.
- hit pipeline, synchronizer, edge detector and prescaler all 0.
- anim_idx=0, FSM state UP.
REQ-017 Reset asserted mid-sprite SHALL drop pixel_on immediately.
REQ-018 After Reset deassertion, the first valid pixel_on SHALL appear 3 clocks after the first sampled hit.
REQ-019 The first animation step after reset SHALL occur on the FRAME_DIV-th frame_clk edge.

Configuration
REQ-020 Macro SPRITE_FLIP_EN: when defined, the block SHALL have an extra input flip_h (1 bit), registered in stage 1; flip_h=1 replaces col with 7-col.
REQ-021 When SPRITE_FLIP_EN is undefined, the flip_h port SHALL be absent and col SHALL always be used unflipped.

Verification
REQ-022 Sprite at (100,50), DrawX=103, DrawY=52 -> read_address=19'd19 after 1 clock; rom_data=24'hFFFF00 -> pixel_on=1, pixel_rgb=24'hFFFF00 after 3 clocks.
REQ-023 DrawX=108 (sprite_x=100) -> read_address=19'd64, pixel_on=0; sprite_x=1020, DrawX=3 -> no hit (no wrap).
REQ-024 Hit with rom_data=24'h000000 -> pixel_on=0, pixel_rgb=0.
REQ-025 FRAME_DIV=2, anim_en=1, 18 frame_clk edges -> frame_sel sequence 1,2,3,4,3,2,1,0,1; anim_en=0 -> frame_sel held.
REQ-026 ghost_mode=1 -> frame_sel=5 on the next clock; release after 4 edges (FRAME_DIV=2) -> frame_sel=2.
REQ-027 With SPRITE_FLIP_EN defined, flip_h=1, row=0, col=1 -> read_address=19'd6; Reset pulsed mid-sprite -> all outputs at reset values within the same clock.
